// File: rtl/k2_pkg.sv
// ----------------------------------------------------------------------------
// k2_pkg
// Shared types and constants for the K2 flag/sequencer path.
//   k2_phase_t : sequencer states (FETCH, EXEC, HALT)
//   K2_DATA_W  : native K2 datapath width
//   k2_is_exec / k2_is_halt : state decode helpers used for the phase outputs
// ----------------------------------------------------------------------------
package k2_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    HALT  = 2'b10
  } k2_phase_t;

  localparam int K2_DATA_W = 4;

  function automatic logic k2_is_exec(input k2_phase_t ph);
    return (ph == EXEC);
  endfunction

  function automatic logic k2_is_halt(input k2_phase_t ph);
    return (ph == HALT);
  endfunction

endpackage

// File: rtl/k2_sat_counter.sv
// ----------------------------------------------------------------------------
// k2_sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Parameters:
//   WIDTH : counter width in bits
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset, clears the count
//   en    in   count one step on this edge
//   count out  current count
// ----------------------------------------------------------------------------
module k2_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Next value with saturation at the top code.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    if (v == {WIDTH{1'b1}}) begin
      return v;
    end
    return v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= sat_inc(count_q);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/k2_flag_seq.sv
// ----------------------------------------------------------------------------
// k2_flag_seq
// Two-phase (FETCH/EXEC) sequencer with HALT, Zero/Carry flag registers and a
// saturating retired-instruction counter for the K2 conditional-jump path.
//
// Parameters:
//   DATA_W   : ALU result width
//   RETIRE_W : retired-instruction counter width
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   stall     in   freezes state, flags and counter
//   halt_req  in   enter HALT from EXEC (level, sampled in EXEC only)
//   resume    in   leave HALT to FETCH (level, honoured in HALT only)
//   alu_res   in   ALU result of the executing instruction
//   alu_cout  in   ALU carry-out of the executing instruction
//   flag_we   in   instruction updates ZF/CF
//   flag_clr  in   instruction clears ZF/CF (wins over flag_we)
//   S_reg     out  phase bit, 1 in EXEC
//   ZF        out  zero flag
//   CF        out  carry flag
//   halted    out  1 in HALT
//   retired   out  saturating count of completed EXEC phases
//
// Build option:
//   K2_FLAG_BYPASS_EN : when defined, ZF/CF show the pending update during an
//   unstalled EXEC cycle so same-cycle consumers see the new flags. The
//   registered flags behave identically either way.
// ----------------------------------------------------------------------------
module k2_flag_seq
  import k2_pkg::*;
#(
  parameter int DATA_W   = K2_DATA_W,
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                halt_req,
  input  logic                resume,
  input  logic [DATA_W-1:0]   alu_res,
  input  logic                alu_cout,
  input  logic                flag_we,
  input  logic                flag_clr,
  output logic                S_reg,
  output logic                ZF,
  output logic                CF,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  k2_phase_t state_q;
  k2_phase_t state_d;
  logic      leave_exec;
  logic      zf_q;
  logic      cf_q;
  logic      zf_d;
  logic      cf_d;

  function automatic logic is_zero(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b0}});
  endfunction

  // An instruction completes on the edge that leaves EXEC unstalled; this is
  // the only point where flags update and the retired count advances.
  assign leave_exec = (state_q == EXEC) && !stall;

  always_comb begin
    state_d = state_q;
    if (!stall) begin
      case (state_q)
        FETCH:   state_d = EXEC;
        EXEC:    state_d = halt_req ? HALT : FETCH;
        HALT:    state_d = resume ? FETCH : HALT;
        default: state_d = FETCH;
      endcase
    end
  end

  // Pending flag value from the executing instruction; clear beats write.
  always_comb begin
    zf_d = zf_q;
    cf_d = cf_q;
    if (flag_clr) begin
      zf_d = 1'b0;
      cf_d = 1'b0;
    end else if (flag_we) begin
      zf_d = is_zero(alu_res);
      cf_d = alu_cout;
    end
  end

  // State and flag registers; async reset discards any in-flight update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (leave_exec) begin
        zf_q <= zf_d;
        cf_q <= cf_d;
      end
    end
  end

  k2_sat_counter #(
    .WIDTH (RETIRE_W)
  ) u_retired (
    .clk   (clk),
    .rst   (rst),
    .en    (leave_exec),
    .count (retired)
  );

  assign S_reg  = k2_is_exec(state_q);
  assign halted = k2_is_halt(state_q);

`ifdef K2_FLAG_BYPASS_EN
  assign ZF = leave_exec ? zf_d : zf_q;
  assign CF = leave_exec ? cf_d : cf_q;
`else
  assign ZF = zf_q;
  assign CF = cf_q;
`endif

endmodule

// File: tb/tb_k2_flag_seq.sv
// ----------------------------------------------------------------------------
// tb_k2_flag_seq
// Self-checking bench for k2_flag_seq. Two instances share all inputs: one
// with the default 16-bit retired counter and one with a 4-bit counter so the
// saturation point is reachable. A behavioural model tracks phase, flags and
// the unbounded instruction count; the expected counter outputs are the
// count clipped to each width's maximum.
// ----------------------------------------------------------------------------
module tb_k2_flag_seq;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          halt_req;
  logic          resume;
  logic [DW-1:0] alu_res;
  logic          alu_cout;
  logic          flag_we;
  logic          flag_clr;

  logic          s_a, zf_a, cf_a, halted_a;
  logic [15:0]   ret_a;
  logic          s_b, zf_b, cf_b, halted_b;
  logic [3:0]    ret_b;

  k2_flag_seq #(.DATA_W(DW), .RETIRE_W(16)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req), .resume(resume),
    .alu_res(alu_res), .alu_cout(alu_cout), .flag_we(flag_we), .flag_clr(flag_clr),
    .S_reg(s_a), .ZF(zf_a), .CF(cf_a), .halted(halted_a), .retired(ret_a)
  );

  k2_flag_seq #(.DATA_W(DW), .RETIRE_W(4)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req), .resume(resume),
    .alu_res(alu_res), .alu_cout(alu_cout), .flag_we(flag_we), .flag_clr(flag_clr),
    .S_reg(s_b), .ZF(zf_b), .CF(cf_b), .halted(halted_b), .retired(ret_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0 = fetch, 1 = exec, 2 = halt.
  int m_phase;
  int m_ret;
  bit m_zf;
  bit m_cf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_ret   = 0;
    m_zf    = 1'b0;
    m_cf    = 1'b0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (!stall) begin
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (flag_clr) begin
          m_zf = 1'b0;
          m_cf = 1'b0;
        end else if (flag_we) begin
          m_zf = (alu_res == 0);
          m_cf = alu_cout;
        end
        m_ret   = m_ret + 1;
        m_phase = halt_req ? 2 : 0;
      end else if (resume) begin
        m_phase = 0;
      end
    end
  endtask

  function automatic bit exp_zf();
`ifdef K2_FLAG_BYPASS_EN
    if (m_phase == 1 && !stall && !rst) begin
      if (flag_clr) return 1'b0;
      if (flag_we)  return (alu_res == 0);
    end
`endif
    return m_zf;
  endfunction

  function automatic bit exp_cf();
`ifdef K2_FLAG_BYPASS_EN
    if (m_phase == 1 && !stall && !rst) begin
      if (flag_clr) return 1'b0;
      if (flag_we)  return alu_cout;
    end
`endif
    return m_cf;
  endfunction

  task automatic compare_all();
    int r16;
    int r4;
    r16 = (m_ret > 65535) ? 65535 : m_ret;
    r4  = (m_ret > 15) ? 15 : m_ret;
    check("S_reg",    32'(s_a),      32'(m_phase == 1));
    check("halted",   32'(halted_a), 32'(m_phase == 2));
    check("ZF",       32'(zf_a),     32'(exp_zf()));
    check("CF",       32'(cf_a),     32'(exp_cf()));
    check("retired",  32'(ret_a),    32'(r16));
    check("S_reg_w4", 32'(s_b),      32'(m_phase == 1));
    check("halt_w4",  32'(halted_b), 32'(m_phase == 2));
    check("ZF_w4",    32'(zf_b),     32'(exp_zf()));
    check("CF_w4",    32'(cf_b),     32'(exp_cf()));
    check("ret_w4",   32'(ret_b),    32'(r4));
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_flags(input bit we, input bit clr, input logic [DW-1:0] res, input bit cout);
    flag_we  = we;
    flag_clr = clr;
    alu_res  = res;
    alu_cout = cout;
  endtask

  task automatic idle_inputs();
    stall    = 1'b0;
    halt_req = 1'b0;
    resume   = 1'b0;
    set_flags(1'b0, 1'b0, '0, 1'b0);
  endtask

  // Async reset pulse placed between clock edges (caller sits at a negedge).
  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all();
    #1 rst = 1'b0;
  endtask

  int r0;

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    compare_all();
    check("rst_sreg", 32'(s_a), 32'd0);
    check("rst_ret",  32'(ret_a), 32'd0);
    rst = 1'b0;

    // Free run: S_reg alternates, three instructions retire in six cycles.
    for (int k = 1; k <= 6; k++) begin
      cycle();
      check("run_sreg", 32'(s_a), 32'(k % 2));
    end
    check("run_ret", 32'(ret_a), 32'd3);
    check("run_zf",  32'(zf_a),  32'd0);

    // Zero result with carry sets both flags; nonzero without carry clears.
    cycle();
    set_flags(1'b1, 1'b0, 4'h0, 1'b1);
    cycle();
    check("we_zero_zf", 32'(zf_a), 32'd1);
    check("we_zero_cf", 32'(cf_a), 32'd1);
    idle_inputs();
    cycle();
    set_flags(1'b1, 1'b0, 4'h5, 1'b0);
    cycle();
    check("we_five_zf", 32'(zf_a), 32'd0);
    check("we_five_cf", 32'(cf_a), 32'd0);

    // Set flags, then clear with we and clr both high.
    idle_inputs();
    cycle();
    set_flags(1'b1, 1'b0, 4'h0, 1'b1);
    cycle();
    idle_inputs();
    cycle();
    set_flags(1'b1, 1'b1, 4'h0, 1'b1);
    cycle();
    check("clr_zf", 32'(zf_a), 32'd0);
    check("clr_cf", 32'(cf_a), 32'd0);

    // Flag write during FETCH is ignored.
    set_flags(1'b1, 1'b0, 4'h0, 1'b1);
    cycle();
    idle_inputs();
    cycle();
    check("fetch_we_zf", 32'(zf_a), 32'd0);
    check("fetch_we_cf", 32'(cf_a), 32'd0);

    // Stall three cycles in EXEC, then the update lands exactly once.
    cycle();
    r0 = ret_a;
    set_flags(1'b1, 1'b0, 4'h0, 1'b1);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("stall_sreg", 32'(s_a),   32'd1);
      check("stall_ret",  32'(ret_a), 32'(r0));
    end
    stall = 1'b0;
    cycle();
    check("unstall_ret", 32'(ret_a), 32'(r0 + 1));
    check("unstall_zf",  32'(zf_a),  32'd1);
    idle_inputs();
    cycle();
    cycle();
    check("once_ret", 32'(ret_a), 32'(r0 + 2));

    // Halt entry, hold for five cycles, resume, then resume in FETCH ignored.
    cycle();
    halt_req = 1'b1;
    cycle();
    check("halt_enter", 32'(halted_a), 32'd1);
    halt_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("halt_hold", 32'(halted_a), 32'd1);
    end
    resume = 1'b1;
    cycle();
    check("resume_halted", 32'(halted_a), 32'd0);
    check("resume_sreg",   32'(s_a),      32'd0);
    cycle();
    check("resume_fetch_sreg", 32'(s_a), 32'd1);
    resume = 1'b0;

    // Saturation of the 4-bit counter after 20 instructions.
    cycle();
    async_reset_pulse();
    for (int k = 0; k < 40; k++) cycle();
    check("sat_w4",  32'(ret_b), 32'hF);
    check("sat_w16", 32'(ret_a), 32'd20);

    // Reset mid-EXEC discards the pending update immediately.
    cycle();
    check("pre_rst_exec", 32'(s_a), 32'd1);
    set_flags(1'b1, 1'b0, 4'h0, 1'b1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("midrst_sreg", 32'(s_a),   32'd0);
    check("midrst_zf",   32'(zf_a),  32'd0);
    check("midrst_ret",  32'(ret_a), 32'd0);
    compare_all();
    #1 rst = 1'b0;
    idle_inputs();

    // Randomized traffic against the model, with occasional async resets.
    for (int k = 0; k < 600; k++) begin
      stall    = ($urandom_range(0, 3) == 0);
      halt_req = ($urandom_range(0, 4) == 0);
      resume   = ($urandom_range(0, 2) == 0);
      set_flags(($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                DW'($urandom_range(0, 3) == 0 ? 0 : $urandom), ($urandom_range(0, 1) == 1));
      cycle();
      if ($urandom_range(0, 49) == 0) async_reset_pulse();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
